addr_seq: RTL

ADDR_SEQ -- requirements
Module: addr_seq

---
 rtl/addr_seq_pkg.sv | 57 +++++
 rtl/addr_seq_len.sv | 48 ++++
 rtl/addr_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/addr_seq_pkg.sv
// Shared 6502 definitions: opcode classes, address sources, sequencer states.
// The OP_* class codes are what the opcode decoder delivers on op_type.
package addr_seq_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_IMP = 5'd0,
    OP_IMM = 5'd1,
    OP_ZPG = 5'd2,
    OP_ZXY = 5'd3,
    OP_ABS = 5'd4,
    OP_AXY = 5'd5,
    OP_XIN = 5'd6,
    OP_INY = 5'd7,
    OP_PUS = 5'd8,
    OP_POP = 5'd9,
    OP_JUM = 5'd10,
    OP_JIN = 5'd11,
    OP_BRA = 5'd12,
    OP_JSR = 5'd13,
    OP_RTS = 5'd14,
    OP_RTI = 5'd15,
    OP_BRK = 5'd16,
    OP_JAM = 5'd17
  } op_t;

  typedef enum logic [2:0] {
    ADR_PC  = 3'd0,
    ADR_ZP  = 3'd1,
    ADR_ABS = 3'd2,
    ADR_IDX = 3'd3,
    ADR_STK = 3'd4,
    ADR_VEC = 3'd5,
    ADR_PTR = 3'd6
  } adr_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_STORE = 2'd1,
    ACC_RMW   = 2'd2
  } acc_t;

  // Neither strobe set is handled like a read: the operand is still fetched.
  function automatic acc_t acc_kind(input logic rd, input logic wr);
    if (rd && wr) return ACC_RMW;
    if (wr) return ACC_STORE;
    return ACC_READ;
  endfunction

endpackage

// File: rtl/addr_seq_len.sv
// seq_len: instruction length lookup (class, access kind, page penalty -> cycles).
// Any class code outside the known set is reported as a JAM.
module seq_len
  import addr_seq_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            rd,
  input  logic            wr,
  input  logic            p,
  output logic [2:0]      len,
  output logic            jam
);

  acc_t acc;

  always_comb begin
    acc = acc_kind(rd, wr);
    len = 3'd2;
    jam = 1'b0;
    case (op)
      OP_IMP, OP_IMM: len = 3'd2;
      OP_ZPG:         len = (acc == ACC_RMW) ? 3'd5 : 3'd3;
      OP_ZXY, OP_ABS: len = (acc == ACC_RMW) ? 3'd6 : 3'd4;
      OP_AXY: begin
        case (acc)
          ACC_RMW:   len = 3'd7;
          ACC_STORE: len = 3'd5;
          default:   len = 3'd4 + {2'b00, p};
        endcase
      end
      // Indexed-indirect RMW would need 8 cycles; it is folded into 6 with a single late write.
      OP_XIN:         len = 3'd6;
      OP_INY:         len = (acc == ACC_READ) ? (3'd5 + {2'b00, p}) : 3'd6;
      OP_PUS:         len = 3'd3;
      OP_POP:         len = 3'd4;
      OP_JUM:         len = 3'd3;
      OP_JIN:         len = 3'd5;
      OP_BRA:         len = 3'd3 + {2'b00, p};
      OP_JSR, OP_RTS, OP_RTI: len = 3'd6;
      OP_BRK:         len = 3'd7;
      default: begin
        len = 3'd7;
        jam = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/addr_seq.sv
// addr_seq: 6502-style T-state sequencer driving address source, R/W and PC increment.
// Build option SEQ_PAGE_PENALTY_EN: page-cross penalty follows page_cross instead of worst case.
module addr_seq
  import addr_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic [OP_W-1:0] op_type,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic            page_cross,
  output logic            sync,
  output logic [2:0]      tstate,
  output logic [2:0]      addr_sel,
  output logic            rw,
  output logic            pc_inc,
  output logic            last,
  output logic            jammed
);

  state_t          state, state_next;
  logic [2:0]      t, t_next;
  logic [OP_W-1:0] op_q;
  logic            rd_q, wr_q, p_q;

  logic [OP_W-1:0] cur_op;
  logic            cur_rd, cur_wr;
  logic            t1, advance;
  logic            p_now, add_cyc, p_eff;
  logic [2:0]      len;
  logic            jam;
  acc_t            acc;
  adr_t            sel;
  logic            wr_cyc, inc;

  // In T1 the decoder outputs are live; afterwards the latched copies take over.
  assign t1     = (state == ST_EXEC) && (t == 3'd1);
  assign cur_op = t1 ? op_type : op_q;
  assign cur_rd = t1 ? mem_rd  : rd_q;
  assign cur_wr = t1 ? mem_wr  : wr_q;

`ifdef SEQ_PAGE_PENALTY_EN
  assign p_now = page_cross;
`else
  assign p_now = page_cross | 1'b1;
`endif

  // The cycle where the adder carry decides whether a fix-up cycle follows.
  assign add_cyc = (state == ST_EXEC) &&
                   (((cur_op == OP_AXY) && (t == 3'd3)) ||
                    ((cur_op == OP_INY) && (t == 3'd4)) ||
                    ((cur_op == OP_BRA) && (t == 3'd2)));
  assign p_eff   = add_cyc ? p_now : p_q;

  seq_len u_len (
    .op  (cur_op),
    .rd  (cur_rd),
    .wr  (cur_wr),
    .p   (p_eff),
    .len (len),
    .jam (jam)
  );

  // Per-cycle bus activity of each instruction class while in EXEC.
  always_comb begin
    acc    = acc_kind(cur_rd, cur_wr);
    sel    = ADR_PC;
    wr_cyc = 1'b0;
    inc    = 1'b0;
    case (cur_op)
      OP_IMM: inc = 1'b1;
      OP_ZPG: begin
        inc = (t == 3'd1);
        if (t >= 3'd2) sel = ADR_ZP;
        wr_cyc = ((acc == ACC_STORE) && (t == 3'd2)) || ((acc == ACC_RMW) && (t >= 3'd3));
      end
      OP_ZXY: begin
        inc = (t == 3'd1);
        if (t == 3'd2) sel = ADR_ZP;
        else if (t >= 3'd3) sel = ADR_IDX;
        wr_cyc = ((acc == ACC_STORE) && (t == 3'd3)) || ((acc == ACC_RMW) && (t >= 3'd4));
      end
      OP_ABS: begin
        inc = (t <= 3'd2);
        if (t >= 3'd3) sel = ADR_ABS;
        wr_cyc = ((acc == ACC_STORE) && (t == 3'd3)) || ((acc == ACC_RMW) && (t >= 3'd4));
      end
      OP_AXY: begin
        inc = (t <= 3'd2);
        if (t >= 3'd3) sel = ADR_IDX;
        wr_cyc = ((acc == ACC_STORE) && (t == 3'd4)) || ((acc == ACC_RMW) && (t >= 3'd5));
      end
      OP_XIN: begin
        inc = (t == 3'd1);
        if (t == 3'd2) sel = ADR_ZP;
        else if ((t == 3'd3) || (t == 3'd4)) sel = ADR_PTR;
        else if (t == 3'd5) sel = ADR_ABS;
        wr_cyc = (acc != ACC_READ) && (t == 3'd5);
      end
      OP_INY: begin
        inc = (t == 3'd1);
        if ((t == 3'd2) || (t == 3'd3)) sel = ADR_PTR;
        else if (t >= 3'd4) sel = ADR_IDX;
        wr_cyc = (acc != ACC_READ) && (t == 3'd5);
      end
      OP_PUS: begin
        if (t == 3'd2) begin
          sel    = ADR_STK;
          wr_cyc = 1'b1;
        end
      end
      OP_POP: if (t >= 3'd2) sel = ADR_STK;
      OP_JUM: inc = 1'b1;
      OP_JIN: begin
        inc = (t <= 3'd2);
        if (t >= 3'd3) sel = ADR_PTR;
      end
      OP_BRA: inc = (t == 3'd1);
      OP_JSR: begin
        inc = (t == 3'd1) || (t == 3'd5);
        if ((t >= 3'd2) && (t <= 3'd4)) sel = ADR_STK;
        wr_cyc = (t == 3'd3) || (t == 3'd4);
      end
      OP_RTS: begin
        inc = (t == 3'd5);
        if ((t >= 3'd2) && (t <= 3'd4)) sel = ADR_STK;
      end
      OP_RTI: if (t >= 3'd2) sel = ADR_STK;
      OP_BRK: begin
        inc = (t == 3'd1);
        if ((t >= 3'd2) && (t <= 3'd4)) begin
          sel    = ADR_STK;
          wr_cyc = 1'b1;
        end else if (t >= 3'd5) begin
          sel = ADR_VEC;
        end
      end
      default: ;
    endcase
  end

  // Reset forces FETCH, so the reset values fall out of the FETCH branch with pc_inc gated.
  always_comb begin
    sync     = 1'b0;
    rw       = 1'b1;
    addr_sel = ADR_PC;
    pc_inc   = 1'b0;
    last     = 1'b0;
    jammed   = 1'b0;
    case (state)
      ST_FETCH: begin
        sync   = 1'b1;
        pc_inc = rst_n;
      end
      ST_EXEC: begin
        addr_sel = sel;
        rw       = ~wr_cyc;
        pc_inc   = inc;
        last     = ~jam && (t == (len - 3'd1));
      end
      ST_HALT: jammed = 1'b1;
      default: ;
    endcase
  end

  assign tstate  = t;
  assign advance = rdy || ~rw;

  always_comb begin
    state_next = state;
    t_next     = t;
    if (advance) begin
      case (state)
        ST_FETCH: begin
          state_next = ST_EXEC;
          t_next     = 3'd1;
        end
        ST_EXEC: begin
          if (t1 && jam) begin
            state_next = ST_HALT;
            t_next     = 3'd0;
          end else if (last) begin
            state_next = ST_FETCH;
            t_next     = 3'd0;
          end else begin
            t_next = t + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      t     <= 3'd0;
      op_q  <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      p_q   <= 1'b0;
    end else begin
      state <= state_next;
      t     <= t_next;
      if (advance) begin
        if (state == ST_FETCH) p_q <= 1'b0;
        if (add_cyc) p_q <= p_now;
        if (t1) begin
          op_q <= op_type;
          rd_q <= mem_rd;
          wr_q <= mem_wr;
        end
      end
    end
  end

endmodule
